// File: rtl/nes_controller_port.sv
// NES controller port: maps two USB keycodes to an 8-button pad, latches on the $4016
// strobe and shifts the pad state out one bit per CPU read of $4016.

module nes_key_match #(
    parameter logic [7:0] KEY = 8'h00
) (
    input  logic [7:0] keycode0,
    input  logic [7:0] keycode1,
    output logic       hit
);
    // Keycode 0 means "no key" and must never press a button.
    assign hit = ((keycode0 == KEY) && (keycode0 != 8'h00)) ||
                 ((keycode1 == KEY) && (keycode1 != 8'h00));
endmodule

module nes_controller_port #(
    parameter logic [7:0] KEY_A      = 8'h1B,
    parameter logic [7:0] KEY_B      = 8'h1D,
    parameter logic [7:0] KEY_SELECT = 8'h2B,
    parameter logic [7:0] KEY_START  = 8'h28,
    parameter logic [7:0] KEY_UP     = 8'h1A,
    parameter logic [7:0] KEY_DOWN   = 8'h16,
    parameter logic [7:0] KEY_LEFT   = 8'h04,
    parameter logic [7:0] KEY_RIGHT  = 8'h07
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_n,
    input  logic       addr,
    input  logic       rw,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    input  logic [7:0] keycode0,
    input  logic [7:0] keycode1,
    output logic [7:0] buttons,
    output logic [3:0] read_count
);
    localparam int NUM_BTN = 8;
    localparam logic [NUM_BTN-1:0][7:0] KEYS = {KEY_RIGHT, KEY_LEFT, KEY_DOWN, KEY_UP,
                                                KEY_START, KEY_SELECT, KEY_B, KEY_A};

    logic [NUM_BTN-1:0] key_hit;
    logic               strobe;
    logic [7:0]         shift;
    logic               wr_strobe;
    logic               rd_pad1;
    logic               rd_pad2;
    logic               unused_data;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_key
        nes_key_match #(.KEY(KEYS[i])) u_match (
            .keycode0 (keycode0),
            .keycode1 (keycode1),
            .hit      (key_hit[i])
        );
    end

    // Only bit 0 of a $4016 write matters; $4017 writes belong to the APU.
    assign unused_data = ^data_in[7:1];
    assign wr_strobe   = !cs_n && !rw && !addr;
    assign rd_pad1     = !cs_n &&  rw && !addr;
    assign rd_pad2     = !cs_n &&  rw &&  addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buttons    <= '0;
            strobe     <= 1'b0;
            shift      <= 8'hFF;
            read_count <= '0;
        end else begin
            buttons <= key_hit;
            if (wr_strobe)
                strobe <= data_in[0];
            // The registered strobe governs this edge, so the 1->0 write still reloads.
            if (strobe) begin
                shift      <= buttons;
                read_count <= '0;
            end else if (rd_pad1) begin
                shift <= {1'b1, shift[7:1]};
                if (read_count != 4'd8)
                    read_count <= read_count + 4'd1;
            end
        end
    end

    always_comb begin
        data_out = 8'h00;
        if (rd_pad1)
            data_out = {7'b0100_000, strobe ? buttons[0] : shift[0]};
        else if (rd_pad2)
            data_out = 8'h40;
    end
endmodule

// File: tb/tb_nes_controller_port.sv
// Bench for nes_controller_port: vector table driven one per cycle, expectations queued on
// drive and compared on the following falling edge.

module tb_nes_controller_port;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs_n = 1'b1;
    logic       addr = 1'b0;
    logic       rw = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic [7:0] keycode0 = 8'h00;
    logic [7:0] keycode1 = 8'h00;
    logic [7:0] buttons;
    logic [3:0] read_count;

    always #5 clk = ~clk;

    nes_controller_port dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cs_n       (cs_n),
        .addr       (addr),
        .rw         (rw),
        .data_in    (data_in),
        .data_out   (data_out),
        .keycode0   (keycode0),
        .keycode1   (keycode1),
        .buttons    (buttons),
        .read_count (read_count)
    );

    // exp_btn / exp_rc are the registered values seen while this vector is applied
    // (result of the previous edge); -1 skips the check.
    typedef struct {
        string      name;
        logic       rst_n;
        logic       cs_n;
        logic       addr;
        logic       rw;
        logic [7:0] din;
        logic [7:0] kc0;
        logic [7:0] kc1;
        logic [7:0] exp_do;
        int         exp_btn;
        int         exp_rc;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic void add(input string nm, input logic r, input logic c, input logic a,
                                input logic w, input logic [7:0] d, input logic [7:0] k0,
                                input logic [7:0] k1, input logic [7:0] dout,
                                input int b, input int rc);
        vec_t v;
        v = '{nm, r, c, a, w, d, k0, k1, dout, b, rc};
        tbl.push_back(v);
    endfunction

    task automatic drive(input vec_t v);
        @(posedge clk);
        #1;
        rst_n    = v.rst_n;
        cs_n     = v.cs_n;
        addr     = v.addr;
        rw       = v.rw;
        data_in  = v.din;
        keycode0 = v.kc0;
        keycode1 = v.kc1;
        sb.push_back(v);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            vec_t e;
            e = sb.pop_front();
            n_cmp++;
            if (data_out !== e.exp_do) begin
                n_err++;
                $display("FAIL %s data_out: got %h want %h", e.name, data_out, e.exp_do);
            end
            if (e.exp_btn >= 0) begin
                n_cmp++;
                if (buttons !== e.exp_btn[7:0]) begin
                    n_err++;
                    $display("FAIL %s buttons: got %h want %h", e.name, buttons, e.exp_btn[7:0]);
                end
            end
            if (e.exp_rc >= 0) begin
                n_cmp++;
                if (read_count !== e.exp_rc[3:0]) begin
                    n_err++;
                    $display("FAIL %s read_count: got %0d want %0d", e.name, read_count, e.exp_rc);
                end
            end
        end
    end

    initial begin
        logic [7:0] keys [8];
        vec_t v;
        keys = '{8'h1B, 8'h1D, 8'h2B, 8'h28, 8'h1A, 8'h16, 8'h04, 8'h07};

        //   name        rst cs a  rw din    kc0    kc1    dout   btn    rc
        add("rst",        0, 1, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        add("t1_rd1",     1, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h41, 8'h00, 0);
        add("t1_rd2",     1, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h41, 8'h00, 1);
        add("t1_rd3",     1, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h41, 8'h00, 2);
        add("t1_idle",    1, 1, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3);
        add("t2_keys",    1, 1, 0, 1, 8'h00, 8'h1B, 8'h28, 8'h00, 8'h00, 3);
        add("t2_stb1",    1, 0, 0, 0, 8'h01, 8'h1B, 8'h28, 8'h00, 8'h09, 3);
        add("t2_stb0",    1, 0, 0, 0, 8'hFE, 8'h1B, 8'h28, 8'h00, 8'h09, 3);
        add("t2_rd1",     1, 0, 0, 1, 8'h00, 8'h1B, 8'h28, 8'h41, 8'h09, 0);
        add("t2_rd2",     1, 0, 0, 1, 8'h00, 8'h1B, 8'h28, 8'h40, 8'h09, 1);
        add("t2_rd3",     1, 0, 0, 1, 8'h00, 8'h1B, 8'h28, 8'h40, 8'h09, 2);
        add("t2_rd4",     1, 0, 0, 1, 8'h00, 8'h1B, 8'h28, 8'h41, 8'h09, 3);
        add("t2_rd5",     1, 0, 0, 1, 8'h00, 8'h1B, 8'h28, 8'h40, 8'h09, 4);
        add("t2_rd6",     1, 0, 0, 1, 8'h00, 8'h1B, 8'h28, 8'h40, 8'h09, 5);
        add("t2_rd7",     1, 0, 0, 1, 8'h00, 8'h1B, 8'h28, 8'h40, 8'h09, 6);
        add("t2_rd8",     1, 0, 0, 1, 8'h00, 8'h1B, 8'h28, 8'h40, 8'h09, 7);
        add("t2_rd9",     1, 0, 0, 1, 8'h00, 8'h1B, 8'h28, 8'h41, 8'h09, 8);
        add("t2_rd10",    1, 0, 0, 1, 8'h00, 8'h1B, 8'h28, 8'h41, 8'h09, 8);
        add("t2_sat",     1, 1, 0, 1, 8'h00, 8'h1B, 8'h28, 8'h00, 8'h09, 8);
        add("t3_stb1",    1, 0, 0, 0, 8'h01, 8'h1B, 8'h00, 8'h00, 8'h09, 8);
        add("t3_live1",   1, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h41, 8'h01, 8);
        add("t3_live0",   1, 0, 0, 1, 8'h00, 8'h1B, 8'h00, 8'h40, 8'h00, 0);
        add("t3_live1b",  1, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h41, 8'h01, 0);
        add("t3_live0b",  1, 0, 0, 1, 8'h00, 8'h1B, 8'h00, 8'h40, 8'h00, 0);
        add("t3_live1c",  1, 0, 0, 1, 8'h00, 8'h1B, 8'h00, 8'h41, 8'h01, 0);
        add("t3_stb0",    1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 0);
        add("t3_rd1",     1, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h41, 8'h00, 0);
        add("t3_rd2",     1, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 1);
        add("t4_left",    1, 1, 0, 1, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 2);
        add("t4_stb1",    1, 0, 0, 0, 8'h01, 8'h04, 8'h00, 8'h00, 8'h40, 2);
        add("t4_stb0",    1, 0, 0, 0, 8'h00, 8'h07, 8'h00, 8'h00, 8'h40, 2);
        add("t4_rd1",     1, 0, 0, 1, 8'h00, 8'h07, 8'h00, 8'h40, 8'h80, 0);
        add("t4_rd2",     1, 0, 0, 1, 8'h00, 8'h07, 8'h00, 8'h40, 8'h80, 1);
        add("t4_rd3",     1, 0, 0, 1, 8'h00, 8'h07, 8'h00, 8'h40, 8'h80, 2);
        add("t4_rd4",     1, 0, 0, 1, 8'h00, 8'h07, 8'h00, 8'h40, 8'h80, 3);
        add("t4_rd5",     1, 0, 0, 1, 8'h00, 8'h07, 8'h00, 8'h40, 8'h80, 4);
        add("t4_rd6",     1, 0, 0, 1, 8'h00, 8'h07, 8'h00, 8'h40, 8'h80, 5);
        add("t5_wr4017",  1, 0, 1, 0, 8'hFF, 8'h07, 8'h00, 8'h00, 8'h80, 6);
        add("t5_rd4017",  1, 0, 1, 1, 8'h00, 8'h07, 8'h00, 8'h40, 8'h80, 6);
        add("t4_rd7",     1, 0, 0, 1, 8'h00, 8'h07, 8'h00, 8'h41, 8'h80, 6);
        add("t4_rd8",     1, 0, 0, 1, 8'h00, 8'h07, 8'h00, 8'h40, 8'h80, 7);
        add("t4_rd9",     1, 0, 0, 1, 8'h00, 8'h07, 8'h00, 8'h41, 8'h80, 8);
        add("t4_idle",    1, 1, 0, 1, 8'h00, 8'h07, 8'h00, 8'h00, 8'h80, 8);
        add("t6_stb1",    1, 0, 0, 0, 8'h01, 8'h1B, 8'h00, 8'h00, 8'h80, 8);
        add("t6_stb0",    1, 0, 0, 0, 8'h00, 8'h1B, 8'h00, 8'h00, 8'h01, 8);
        add("t6_rd1",     1, 0, 0, 1, 8'h00, 8'h1B, 8'h00, 8'h41, 8'h01, 0);
        add("t6_rd2",     1, 0, 0, 1, 8'h00, 8'h1B, 8'h00, 8'h40, 8'h01, 1);
        add("t6_rd3",     1, 0, 0, 1, 8'h00, 8'h1B, 8'h00, 8'h40, 8'h01, 2);
        add("t6_rst",     0, 1, 0, 1, 8'h00, 8'h1B, 8'h00, 8'h00, 8'h00, 0);
        add("t6_rd_post", 1, 0, 0, 1, 8'h00, 8'h1B, 8'h00, 8'h41, 8'h00, 0);
        add("t6_remap",   1, 0, 0, 1, 8'h00, 8'h1B, 8'h00, 8'h41, 8'h01, 1);
        add("t6_idle",    1, 1, 0, 1, 8'h00, 8'h1B, 8'h00, 8'h00, 8'h01, 2);

        for (int i = 0; i < tbl.size(); i++)
            drive(tbl[i]);

        // Every button through keycode slot 1, one-cycle latency each.
        for (int i = 0; i < 8; i++) begin
            v = '{$sformatf("map_set%0d", i), 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, keys[i],
                  8'h00, -1, 2};
            drive(v);
            v.name    = $sformatf("map_btn%0d", i);
            v.exp_btn = 1 << i;
            drive(v);
        end
        // Both slots at once, then no key at all.
        v = '{"map_both_set", 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h04, 8'h07, 8'h00, -1, 2};
        drive(v);
        v.name = "map_both"; v.exp_btn = 8'hC0;
        drive(v);
        v = '{"map_none_set", 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC0, 2};
        drive(v);
        v.name = "map_none"; v.exp_btn = 8'h00;
        drive(v);

        for (int i = 0; i < 10 && sb.size() > 0; i++)
            @(posedge clk);
        #6;
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
